// File: rtl/ifu_pkg.sv
// ifu_pkg: shared definitions for the instruction-fetch front end.
//   Default widths (IFU_DATA_W, IFU_ADDR_W, IFU_PID_W), packet-ID reset value
//   and step, and occ_w(), the width of an occupancy counter able to hold
//   0..DEPTH inclusive.
package ifu_pkg;

  localparam int IFU_DATA_W   = 32;
  localparam int IFU_ADDR_W   = 32;
  localparam int IFU_PID_W    = 2;
  localparam int IFU_PID_INIT = 2;
  localparam int IFU_PID_STEP = 2;

  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifu_sync_fifo.sv
// ifu_sync_fifo: circular buffer of DEPTH entries, WIDTH bits each.
//   clk, reset_n   clock, synchronous active-low reset (pointers/count only)
//   push, push_data  write one entry (ignored when full and not popping)
//   pop            retire the head entry (ignored when empty)
//   flush          discard all entries; wins over push/pop in the same cycle
//   head           combinational read of the oldest entry
//   count          occupancy, 0..DEPTH
module ifu_sync_fifo
  import ifu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  input  logic                      flush,
  output logic [WIDTH-1:0]          head,
  output logic [occ_w(DEPTH)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = occ_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (count != '0);
  // A pop in the same cycle frees the slot, so a full buffer may still accept.
  assign do_push = push & ((count < CW'(DEPTH)) | do_pop);
  assign head    = mem[rd_ptr];

  // Storage carries data only; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: single-way instruction fetch front end.
//   Issues credit-limited fetch requests, collects in-order memory responses
//   in a DEPTH-entry queue (or bypasses it when empty), and delivers one
//   instruction per cycle to decode with a wrapping packet ID. A jump flushes
//   the queue and discards responses still in flight.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   valid_i, instAddr_i     fetch address from the PC stage
//   request_o, instAddr_fetch_o  fetch request and address to memory
//   dataOk_i, inst_fetch_i  memory response (in order)
//   jumpFlag_i              redirect/flush
//   ready_i / ready_o       decode can accept / delivery this cycle
//   valid_o, inst_o, pid_o  registered delivered instruction and packet ID
//   instAddr_o              address of inst_o (only with INST_ADDR_TRACE_EN)
//   count_o                 queue occupancy
// Build option: define INST_ADDR_TRACE_EN to add the instAddr_o trace queue.
module inst_fetch_queue
  import ifu_pkg::*;
#(
  parameter int DATA_W   = IFU_DATA_W,
  parameter int ADDR_W   = IFU_ADDR_W,
  parameter int DEPTH    = 4,
  parameter int PID_W    = IFU_PID_W,
  parameter int PID_INIT = IFU_PID_INIT,
  parameter int PID_STEP = IFU_PID_STEP
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     valid_i,
  input  logic [ADDR_W-1:0]        instAddr_i,
  output logic                     request_o,
  output logic [ADDR_W-1:0]        instAddr_fetch_o,
  input  logic                     dataOk_i,
  input  logic [DATA_W-1:0]        inst_fetch_i,
  input  logic                     jumpFlag_i,
  input  logic                     ready_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output logic [DATA_W-1:0]        inst_o,
  output logic [PID_W-1:0]         pid_o,
`ifdef INST_ADDR_TRACE_EN
  output logic [ADDR_W-1:0]        instAddr_o,
`endif
  output logic [occ_w(DEPTH)-1:0]  count_o
);

  localparam int CW = occ_w(DEPTH);
  // Repeated flushes can stack discards beyond DEPTH, so drop gets headroom.
  localparam int DW = CW + 2;

  function automatic logic [PID_W-1:0] pid_advance(input logic [PID_W-1:0] p);
    return p + PID_W'(PID_STEP);
  endfunction

  logic [CW-1:0]     count;
  logic [CW-1:0]     pending;
  logic [DW-1:0]     drop;
  logic [CW:0]       inflight;
  logic              acc;
  logic              deliver;
  logic              head_sel;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] src;

  logic              vld_p1;
  logic [DATA_W-1:0] inst_p1;
  logic [PID_W-1:0]  pid_p1;

  // Stage 0: credit, response acceptance, delivery select
  assign inflight         = {1'b0, count} + {1'b0, pending};
  assign request_o        = valid_i & ~jumpFlag_i & (inflight < (CW+1)'(DEPTH));
  assign instAddr_fetch_o = instAddr_i;

  // A response with nothing outstanding (and no request this cycle) is noise.
  assign acc      = dataOk_i & (drop == '0) & ((pending != '0) | request_o);
  assign head_sel = (count != '0);
  assign deliver  = ready_i & ~jumpFlag_i & (head_sel | acc);
  assign ready_o  = deliver;
  assign src      = head_sel ? head : inst_fetch_i;
  // Queue the response unless it went straight out through the bypass.
  assign push     = acc & ~jumpFlag_i & ~(deliver & ~head_sel);
  assign pop      = deliver & head_sel;
  assign count_o  = count;

  ifu_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_data_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (inst_fetch_i),
    .pop       (pop),
    .flush     (jumpFlag_i),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending <= '0;
      drop    <= '0;
    end else if (jumpFlag_i) begin
      // Everything outstanding becomes a discard; a same-cycle response
      // (whether already a discard or the oldest pending one) is consumed now.
      pending <= '0;
      drop    <= drop + DW'(pending)
                 - DW'(dataOk_i && ((drop != '0) || (pending != '0)));
    end else begin
      pending <= pending + CW'(request_o) - CW'(acc);
      if (dataOk_i && (drop != '0)) drop <= drop - DW'(1);
    end
  end

  // Stage 1: registered delivery to decode
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      inst_p1 <= '0;
      pid_p1  <= PID_W'(PID_INIT);
    end else begin
      vld_p1 <= deliver;
      if (deliver) begin
        inst_p1 <= src;
        pid_p1  <= pid_advance(pid_p1);
      end
    end
  end

  assign valid_o = vld_p1;
  assign inst_o  = inst_p1;
  assign pid_o   = pid_p1;

`ifdef INST_ADDR_TRACE_EN
  // Addresses enter at request time, so this queue holds queued plus
  // pending entries; its head is always the address of the next delivery.
  logic [CW-1:0]     addr_count;
  logic [ADDR_W-1:0] addr_head;
  logic [ADDR_W-1:0] addr_src;
  logic              addr_sel;
  logic              addr_push;
  logic              addr_pop;
  logic [ADDR_W-1:0] addr_p1;

  assign addr_sel  = (addr_count != '0);
  assign addr_src  = addr_sel ? addr_head : instAddr_i;
  assign addr_push = request_o & ~(deliver & ~addr_sel);
  assign addr_pop  = deliver & addr_sel;

  ifu_sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_addr_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (addr_push),
    .push_data (instAddr_i),
    .pop       (addr_pop),
    .flush     (jumpFlag_i),
    .head      (addr_head),
    .count     (addr_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_p1 <= '0;
    end else if (deliver) begin
      addr_p1 <= addr_src;
    end
  end

  assign instAddr_o = addr_p1;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (default parameters). Define
// INST_ADDR_TRACE_EN for both RTL and bench to cover the address trace.
`define CHK(tag, obs, exp) chk(tag, 64'(obs), 64'(exp))

module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_i;
  logic [31:0] instAddr_i;
  logic        request_o;
  logic [31:0] instAddr_fetch_o;
  logic        dataOk_i;
  logic [31:0] inst_fetch_i;
  logic        jumpFlag_i;
  logic        ready_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] inst_o;
  logic [1:0]  pid_o;
  logic [2:0]  count_o;
`ifdef INST_ADDR_TRACE_EN
  logic [31:0] instAddr_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  inst_fetch_queue dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .valid_i          (valid_i),
    .instAddr_i       (instAddr_i),
    .request_o        (request_o),
    .instAddr_fetch_o (instAddr_fetch_o),
    .dataOk_i         (dataOk_i),
    .inst_fetch_i     (inst_fetch_i),
    .jumpFlag_i       (jumpFlag_i),
    .ready_i          (ready_i),
    .ready_o          (ready_o),
    .valid_o          (valid_o),
    .inst_o           (inst_o),
    .pid_o            (pid_o),
`ifdef INST_ADDR_TRACE_EN
    .instAddr_o       (instAddr_o),
`endif
    .count_o          (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] a, input logic ok,
                     input logic [31:0] d, input logic j, input logic r);
    valid_i      = v;
    instAddr_i   = a;
    dataOk_i     = ok;
    inst_fetch_i = d;
    jumpFlag_i   = j;
    ready_i      = r;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    `CHK("rst_valid", valid_o, 1'b0);
    `CHK("rst_inst", inst_o, 32'h0);
    `CHK("rst_pid", pid_o, 2'd2);
    `CHK("rst_count", count_o, 3'd0);
    `CHK("rst_req", request_o, 1'b0);
`ifdef INST_ADDR_TRACE_EN
    `CHK("rst_addr", instAddr_o, 32'h0);
`endif

    // Bypass: same-cycle response delivered next cycle, pid 2+2 -> 0
    drv(1'b1, 32'h8000_0000, 1'b1, 32'h0000_0013, 1'b0, 1'b1);
    #1;
    `CHK("byp_req", request_o, 1'b1);
    `CHK("byp_fetch_addr", instAddr_fetch_o, 32'h8000_0000);
    `CHK("byp_ready_o", ready_o, 1'b1);
    cyc();
    n_vec++;
    if (valid_o !== 1'b1) begin
      n_err++;
      $error("FAIL byp_valid observed=%0h expected=1", valid_o);
    end
    n_vec++;
    if (inst_o !== 32'h13) begin
      n_err++;
      $error("FAIL byp_inst observed=%0h expected=13", inst_o);
    end
    n_vec++;
    if (pid_o !== 2'd0) begin
      n_err++;
      $error("FAIL byp_pid observed=%0h expected=0", pid_o);
    end
    `CHK("byp_count", count_o, 3'd0);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc();
    `CHK("byp_idle_valid", valid_o, 1'b0);
    `CHK("byp_idle_inst", inst_o, 32'h13);
    `CHK("byp_idle_pid", pid_o, 2'd0);

    // Backpressure fill to DEPTH, then drain four in a row
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 32'h1000 + 32'(k * 4), 1'b1, 32'hA0 + 32'(k), 1'b0, 1'b0);
      #1;
      n_vec++;
      if (request_o !== 1'b1) begin
        n_err++;
        $error("FAIL fill_req observed=%0h expected=1", request_o);
      end
      cyc();
    end
    `CHK("fill_count", count_o, 3'd4);
    `CHK("fill_valid", valid_o, 1'b0);
    drv(1'b1, 32'h2000, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    `CHK("full_req", request_o, 1'b0);
    cyc();
    `CHK("full_count", count_o, 3'd4);
    drv(1'b1, 32'h2000, 1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    `CHK("drain_req_full", request_o, 1'b0);
    `CHK("drain_ready_o", ready_o, 1'b1);
    cyc();
    `CHK("drain0_valid", valid_o, 1'b1);
    `CHK("drain0_inst", inst_o, 32'hA0);
    `CHK("drain0_pid", pid_o, 2'd0);
    `CHK("drain0_count", count_o, 3'd3);
    `CHK("credit_back_req", request_o, 1'b1);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc();
    `CHK("drain1_inst", inst_o, 32'hA1);
    `CHK("drain1_pid", pid_o, 2'd2);
    cyc();
    `CHK("drain2_inst", inst_o, 32'hA2);
    `CHK("drain2_pid", pid_o, 2'd0);
    cyc();
    `CHK("drain3_valid", valid_o, 1'b1);
    `CHK("drain3_inst", inst_o, 32'hA3);
    `CHK("drain3_pid", pid_o, 2'd2);
    `CHK("drain3_count", count_o, 3'd0);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc();
    `CHK("drain_end_valid", valid_o, 1'b0);

    // Simultaneous push and pop at count 2
    do_reset();
    drv(1'b1, 32'h3000, 1'b1, 32'hC0, 1'b0, 1'b0);
    cyc();
    drv(1'b1, 32'h3004, 1'b1, 32'hC1, 1'b0, 1'b0);
    cyc();
    `CHK("pp_pre_count", count_o, 3'd2);
    drv(1'b1, 32'h3008, 1'b1, 32'hC2, 1'b0, 1'b1);
    cyc();
    `CHK("pp_count", count_o, 3'd2);
    `CHK("pp_inst0", inst_o, 32'hC0);
    `CHK("pp_pid0", pid_o, 2'd0);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc();
    `CHK("pp_inst1", inst_o, 32'hC1);
    `CHK("pp_count1", count_o, 3'd1);
    cyc();
    `CHK("pp_inst2", inst_o, 32'hC2);
    `CHK("pp_count2", count_o, 3'd0);

    // Flush with one queued entry and two pending requests
    do_reset();
    drv(1'b1, 32'h4000, 1'b1, 32'hE0, 1'b0, 1'b0);
    cyc();
    drv(1'b1, 32'h4004, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc();
    drv(1'b1, 32'h4008, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc();
    `CHK("fl_pre_count", count_o, 3'd1);
    drv(1'b1, 32'h400C, 1'b0, 32'h0, 1'b1, 1'b1);
    #1;
    `CHK("fl_req", request_o, 1'b0);
    `CHK("fl_ready_o", ready_o, 1'b0);
    cyc();
    `CHK("fl_count", count_o, 3'd0);
    `CHK("fl_valid", valid_o, 1'b0);
    drv(1'b0, 32'h0, 1'b1, 32'hDEAD_0001, 1'b0, 1'b1);
    #1;
    `CHK("fl_drop1_ready_o", ready_o, 1'b0);
    cyc();
    `CHK("fl_drop1_valid", valid_o, 1'b0);
    drv(1'b0, 32'h0, 1'b1, 32'hDEAD_0002, 1'b0, 1'b1);
    #1;
    `CHK("fl_drop2_ready_o", ready_o, 1'b0);
    cyc();
    `CHK("fl_drop2_count", count_o, 3'd0);
    drv(1'b0, 32'h0, 1'b1, 32'hDEAD_0003, 1'b0, 1'b1);
    #1;
    `CHK("stray_ready_o", ready_o, 1'b0);
    cyc();
    `CHK("stray_valid", valid_o, 1'b0);
    drv(1'b1, 32'h5000, 1'b1, 32'hB0, 1'b0, 1'b1);
    cyc();
    `CHK("fl_b0_valid", valid_o, 1'b1);
    `CHK("fl_b0_inst", inst_o, 32'hB0);
    `CHK("fl_b0_pid", pid_o, 2'd0);

    // Reset in the middle of a stream with count 3
    do_reset();
    drv(1'b1, 32'h6000, 1'b1, 32'h13, 1'b0, 1'b1);
    cyc();
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 32'h6004 + 32'(k * 4), 1'b1, 32'hF0 + 32'(k), 1'b0, 1'b0);
      cyc();
    end
    `CHK("mr_pre_count", count_o, 3'd3);
    `CHK("mr_pre_pid", pid_o, 2'd0);
    reset_n = 1'b0;
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc();
    `CHK("mr_valid", valid_o, 1'b0);
    `CHK("mr_inst", inst_o, 32'h0);
    `CHK("mr_pid", pid_o, 2'd2);
    `CHK("mr_count", count_o, 3'd0);
    reset_n = 1'b1;
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    `CHK("mr_post_ready_o", ready_o, 1'b0);
    cyc();
    `CHK("mr_post_valid", valid_o, 1'b0);

`ifdef INST_ADDR_TRACE_EN
    // Address trace follows inst_o through the queue and the bypass
    do_reset();
    drv(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc();
    drv(1'b1, 32'h8000_0004, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc();
    drv(1'b0, 32'h0, 1'b1, 32'h11, 1'b0, 1'b0);
    cyc();
    drv(1'b0, 32'h0, 1'b1, 32'h22, 1'b0, 1'b0);
    cyc();
    `CHK("tr_count", count_o, 3'd2);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc();
    `CHK("tr_inst0", inst_o, 32'h11);
    `CHK("tr_addr0", instAddr_o, 32'h8000_0000);
    cyc();
    `CHK("tr_inst1", inst_o, 32'h22);
    `CHK("tr_addr1", instAddr_o, 32'h8000_0004);
    drv(1'b1, 32'h8000_0008, 1'b1, 32'h33, 1'b0, 1'b1);
    cyc();
    `CHK("tr_inst2", inst_o, 32'h33);
    `CHK("tr_addr2", instAddr_o, 32'h8000_0008);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`undef CHK

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Parametrised instruction-fetch front end for one issue way. It forwards fetch requests to instruction memory and collects in-order responses in a DEPTH-entry queue. It delivers one instruction per cycle to decode together with a wrapping packet ID. It adds credit-based request throttling, multi-entry buffering and jump flush with discard of in-flight responses.

## Interface
Parameters:
- DATA_W, 32, instruction width
- ADDR_W, 32, fetch address width
- DEPTH, 4, queue entries (power of two, ≥2)
- PID_W, 2, packet-ID width
- PID_INIT, 2, packet-ID reset value
- PID_STEP, 2, packet-ID increment per delivered instruction

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- valid_i  in  1  PC stage has a fetch address
- instAddr_i  in  ADDR_W  fetch address
- request_o  out  1  fetch request to memory
- instAddr_fetch_o  out  ADDR_W  = instAddr_i
- dataOk_i  in  1  memory response valid (same cycle as request or later, in order)
- inst_fetch_i  in  DATA_W  memory response data
- jumpFlag_i  in  1  flush (redirect)
- ready_i  in  1  decode can accept
- ready_o  out  1  delivery occurs this cycle (combinational)
- valid_o  out  1  inst_o/pid_o valid (one-cycle pulse per instruction)
- inst_o  out  DATA_W  delivered instruction
- pid_o  out  PID_W  packet ID
- count_o  out  clog2(DEPTH)+1  queue occupancy

## Operation
- pending = accepted requests without a response. drop = responses still to discard.
- Credit: request_o = valid_i & ~jumpFlag_i & (count + pending < DEPTH).
- Response accepted when dataOk_i & (drop == 0). When drop > 0, the response is discarded and drop decrements.
- Delivery (ready_o=1) when ready_i & ~jumpFlag_i & (count > 0 | accepted response).
  - Source is the queue head if count > 0; otherwise the response bypasses the queue.
  - A response arriving while the head is popped is pushed, so order is preserved.
- Accepted response not delivered this cycle → pushed. Overflow is impossible by credit.
- On delivery, next cycle: inst_o = source, valid_o = 1, pid_o += PID_STEP (mod 2^PID_W). Otherwise valid_o = 0 and inst_o/pid_o hold.
- pending_next = pending + request_o − (dataOk_i & drop==0).
- Flush (jumpFlag_i=1):
  - Queue cleared and no request issued.
  - drop_next = drop + pending − (dataOk_i ? 1 : 0), where a same-cycle response is discarded.
  - pending_next = 0 and valid_o = 0 next cycle.
  - pid_o is not reset.
- dataOk_i with pending == 0 and no same-cycle request: ignored.
- Reset (any cycle, including mid-stream): inst_o=0, valid_o=0, pid_o=PID_INIT, count=0, pending=0, drop=0. Queue contents are discarded.

## Timing
- Bypass latency: dataOk_i at cycle N with ready_i → valid_o at N+1.
- Queue delivery: head appears on valid_o the cycle after ready_i is sampled high.
- Throughput: 1 instruction/cycle sustained when ready_i=1 and memory streams.
- Full (count + pending == DEPTH): request_o=0 while valid_i=1. request_o rises the cycle after a pop frees credit.
- Simultaneous push + pop at count == DEPTH−1 or count == 1: occupancy unchanged and order kept.
- Flush has priority over delivery, push and request in the same cycle.

## Configuration
- INST_ADDR_TRACE_EN defined:
  - Adds output instAddr_o [ADDR_W].
  - A parallel DEPTH-entry address queue captures instAddr_i at request time.
  - instAddr_o updates with inst_o, reset value 0, and is flushed identically.
- Undefined: no port and no address storage.

## Structure
- Shared package ifu_pkg holds:
  - default widths DATA_W, ADDR_W, PID_W
  - PID_INIT and PID_STEP constants
  - a clog2-based occupancy-width function
- One sub-module, ifu_sync_fifo:
  - parametrised width/depth circular buffer, synchronous active-low reset
  - push, pop, flush, count, and head read
  - instantiated once for data and once more under INST_ADDR_TRACE_EN
- Top level holds credit, pending/drop counters, bypass mux and output register.

## Test plan
- Bypass: valid_i=1, dataOk_i same cycle with 0x00000013, ready_i=1 → next cycle valid_o=1, inst_o=0x00000013, pid_o=0 (2+2 mod 4).
- Backpressure fill: ready_i=0, four responses 0xA0..0xA3 → count_o=4, request_o=0. Release ready_i → valid_o for 4 consecutive cycles with 0xA0..0xA3, pid 0,2,0,2.
- Simultaneous push/pop: count=2, ready_i=1, dataOk_i=1 → count_o stays 2 and output order is preserved.
- Flush with 2 pending: jumpFlag_i=1 → count_o=0 and valid_o=0 next cycle. The next 2 dataOk_i are discarded. A third response (0xB0) is delivered.
- Reset mid-stream with count=3: reset_n=0 for 1 cycle → valid_o=0, inst_o=0, pid_o=2, count_o=0.
- INST_ADDR_TRACE_EN: requests at 0x80000000, 0x80000004 with delayed delivery → instAddr_o tracks inst_o pairwise.
